// File: rtl/uart_tx_fifo.sv
// Buffered 8N1/8N2 UART transmitter: a DEPTH-entry byte FIFO drained LSB-first onto tx_o.
// Bit period and stop-bit count are captured per frame when the byte is popped.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cfg_en_i,
  input  logic [15:0]   cfg_div_i,
  input  logic          cfg_stop_bits_i,
  input  logic [7:0]    wr_data_i,
  input  logic          wr_valid_i,
  output logic          wr_ready_o,
  output logic          tx_o,
  output logic          busy_o,
  output logic [AW:0]   level_o
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [15:0]   cnt, cnt_n, div_lat, div_n, div_eff;
  logic [7:0]    shift, shift_n;
  logic [2:0]    bit_idx, bit_n;
  logic          stop_idx, stop_n, stop2_lat, stop2_n, tx_n;
  logic          pop, can_pop, wr_fire;

  assign wr_ready_o = (count != FULL);
  assign wr_fire    = wr_valid_i & wr_ready_o;
  assign can_pop    = cfg_en_i & (count != '0);
  assign div_eff    = (cfg_div_i < 16'd2) ? 16'd2 : cfg_div_i;
  assign level_o    = count;

  // Next-state and datapath: each phase counts down div_lat-1..0, then advances.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shift_n = shift;
    bit_n   = bit_idx;
    stop_n  = stop_idx;
    div_n   = div_lat;
    stop2_n = stop2_lat;
    tx_n    = tx_o;
    pop     = 1'b0;
    case (state)
      IDLE: pop = can_pop;
      START: begin
        if (cnt == 16'd0) begin
          state_n = DATA;
          cnt_n   = div_lat - 16'd1;
          tx_n    = shift[0];
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      DATA: begin
        if (cnt == 16'd0) begin
          cnt_n = div_lat - 16'd1;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            stop_n  = 1'b0;
            tx_n    = 1'b1;
          end else begin
            shift_n = {1'b0, shift[7:1]};
            tx_n    = shift[1];
            bit_n   = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      STOP: begin
        if (cnt == 16'd0) begin
          if (stop2_lat && !stop_idx) begin
            stop_n = 1'b1;
            cnt_n  = div_lat - 16'd1;
          end else if (can_pop) begin
            pop = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
    // Popping starts a frame back-to-back: start bit drives out at the pop edge.
    if (pop) begin
      state_n = START;
      shift_n = mem[rd_ptr];
      cnt_n   = div_eff - 16'd1;
      div_n   = div_eff;
      stop2_n = cfg_stop_bits_i;
      bit_n   = 3'd0;
      stop_n  = 1'b0;
      tx_n    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      shift     <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      div_lat   <= 16'd2;
      stop2_lat <= 1'b0;
      tx_o      <= 1'b1;
      busy_o    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      shift     <= shift_n;
      bit_idx   <= bit_n;
      stop_idx  <= stop_n;
      div_lat   <= div_n;
      stop2_lat <= stop2_n;
      tx_o      <= tx_n;
      busy_o    <= (state_n != IDLE);
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-two DEPTH.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({wr_fire, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_fire) mem[wr_ptr] <= wr_data_i;
  end

endmodule
